// File: rtl/s_rd_sched.sv
// Read-port scheduler for the S coefficient memory: arbitrates the single
// synchronous read port between the EVP and EVB engines and tags returned data.
module s_rd_sched #(
   parameter int s_size    = 88,
   parameter int word_size = 16,
   localparam int aw = (s_size > 1) ? $clog2(s_size) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           instr,
   input  logic                 instr_valid,
   input  logic                 op_done,
   input  logic                 evp_req,
   input  logic [aw-1:0]        evp_addr,
   input  logic                 evb_req,
   input  logic [aw-1:0]        evb_addr,
   output logic                 evp_grant,
   output logic                 evb_grant,
   output logic                 rd_en_S,
   output logic [aw-1:0]        rd_addr_S,
   input  logic [word_size-1:0] data_S,
   output logic [word_size-1:0] evp_rdata,
   output logic [word_size-1:0] evb_rdata,
   output logic                 evp_rvalid,
   output logic                 evb_rvalid,
   output logic                 addr_err,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE,
      OWN_EVP,
      OWN_EVB,
      LOCK_STP,
      DRAIN
   } state_t;

   localparam logic [aw:0] size_lim = (aw+1)'(s_size);

   state_t state, state_next;

   logic tag1_valid, tag1_owner;
   logic tag2_valid, tag2_owner;
   logic evp_in_range, evb_in_range;
   logic grant_any, err_req, idle_clear;

   assign evp_in_range = ({1'b0, evp_addr} < size_lim);
   assign evb_in_range = ({1'b0, evb_addr} < size_lim);

   assign evp_grant  = (state == OWN_EVP) && evp_req && evp_in_range;
   assign evb_grant  = (state == OWN_EVB) && evb_req && evb_in_range;
   assign grant_any  = evp_grant || evb_grant;
   assign err_req    = ((state == OWN_EVP) && evp_req && !evp_in_range) ||
                       ((state == OWN_EVB) && evb_req && !evb_in_range);
   assign idle_clear = (state == IDLE) && instr_valid && (instr == 2'b11);

   // Leaving DRAIN looks one stage ahead so IDLE coincides with an empty pipeline.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (instr_valid) begin
               case (instr)
                  2'b01:   state_next = OWN_EVP;
                  2'b10:   state_next = OWN_EVB;
                  2'b00:   state_next = LOCK_STP;
                  default: state_next = IDLE;
               endcase
            end
         end
         OWN_EVP, OWN_EVB, LOCK_STP: begin
            if (op_done) state_next = DRAIN;
         end
         DRAIN: begin
            if (!tag1_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rd_en_S    <= 1'b0;
         rd_addr_S  <= '0;
         addr_err   <= 1'b0;
         tag1_valid <= 1'b0;
         tag1_owner <= 1'b0;
         tag2_valid <= 1'b0;
         tag2_owner <= 1'b0;
      end else begin
         state      <= state_next;
         rd_en_S    <= grant_any;
         if (grant_any) rd_addr_S <= evb_grant ? evb_addr : evp_addr;
         addr_err   <= err_req && !idle_clear;
         tag1_valid <= grant_any && !idle_clear;
         tag1_owner <= evb_grant;
         tag2_valid <= tag1_valid && !idle_clear;
         tag2_owner <= tag1_owner;
      end
   end

   assign evp_rdata  = data_S;
   assign evb_rdata  = data_S;
   assign evp_rvalid = tag2_valid && !tag2_owner;
   assign evb_rvalid = tag2_valid && tag2_owner;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_s_rd_sched.sv
// Randomized self-checking bench for s_rd_sched against a queue-based
// model of ownership, grants and return timing.
module tb_s_rd_sched;

   localparam int S_SIZE = 88;
   localparam int WORD   = 16;
   localparam int AW     = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      instr;
   logic            instr_valid, op_done;
   logic            evp_req, evb_req;
   logic [AW-1:0]   evp_addr, evb_addr;
   logic            evp_grant, evb_grant;
   logic            rd_en_S;
   logic [AW-1:0]   rd_addr_S;
   logic [WORD-1:0] data_S, evp_rdata, evb_rdata;
   logic            evp_rvalid, evb_rvalid, addr_err, busy;

   always #5 clk = ~clk;

   s_rd_sched #(.s_size(S_SIZE), .word_size(WORD)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .op_done(op_done), .evp_req(evp_req), .evp_addr(evp_addr),
      .evb_req(evb_req), .evb_addr(evb_addr), .evp_grant(evp_grant),
      .evb_grant(evb_grant), .rd_en_S(rd_en_S), .rd_addr_S(rd_addr_S),
      .data_S(data_S), .evp_rdata(evp_rdata), .evb_rdata(evb_rdata),
      .evp_rvalid(evp_rvalid), .evb_rvalid(evb_rvalid),
      .addr_err(addr_err), .busy(busy)
   );

   int compared   = 0;
   int mismatched = 0;

   // Model: who owns S, outstanding returns as (due cycle, owner=1 for EVB).
   typedef enum int {M_IDLE, M_EVP, M_EVB, M_STP, M_DRAIN} mode_t;
   mode_t         mode = M_IDLE;
   int            cyc = 0;
   int            due_q[$];
   bit            own_q[$];
   bit            exp_rd_en = 1'b0;
   bit            exp_err   = 1'b0;
   logic [AW-1:0] exp_rd_addr = '0;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, want);
      end
   endtask

   function automatic bit return_due(input bit owner, input int c);
      for (int i = 0; i < due_q.size(); i++)
         if (due_q[i] == c && own_q[i] == owner) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: entered and left at posedge+1.
   task automatic apply_stimulus(input bit iv, input int ins, input bit od,
                                 input bit pr, input int pa, input bit br, input int ba);
      bit gp, gb, bad_p, bad_b;
      check_output("rd_en_S",    rd_en_S,    exp_rd_en);
      check_output("rd_addr_S",  rd_addr_S,  exp_rd_addr);
      check_output("addr_err",   addr_err,   exp_err);
      check_output("busy",       busy,       mode != M_IDLE);
      check_output("evp_rvalid", evp_rvalid, return_due(1'b0, cyc));
      check_output("evb_rvalid", evb_rvalid, return_due(1'b1, cyc));

      instr_valid = iv;
      instr       = ins[1:0];
      op_done     = od;
      evp_req     = pr;
      evp_addr    = pa[AW-1:0];
      evb_req     = br;
      evb_addr    = ba[AW-1:0];
      data_S      = WORD'($urandom);
      #2;

      gp    = (mode == M_EVP) && pr && (pa <  S_SIZE);
      gb    = (mode == M_EVB) && br && (ba <  S_SIZE);
      bad_p = (mode == M_EVP) && pr && (pa >= S_SIZE);
      bad_b = (mode == M_EVB) && br && (ba >= S_SIZE);
      check_output("evp_grant", evp_grant, gp);
      check_output("evb_grant", evb_grant, gb);
      check_output("evp_rdata", evp_rdata, data_S);
      check_output("evb_rdata", evb_rdata, data_S);

      exp_rd_en = gp || gb;
      if (gp) exp_rd_addr = pa[AW-1:0];
      if (gb) exp_rd_addr = ba[AW-1:0];
      if (gp || gb) begin
         due_q.push_back(cyc + 2);
         own_q.push_back(gb);
      end
      exp_err = bad_p || bad_b;
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         void'(own_q.pop_front());
      end

      case (mode)
         M_IDLE: if (iv) begin
            if (ins == 1)      mode = M_EVP;
            else if (ins == 2) mode = M_EVB;
            else if (ins == 0) mode = M_STP;
         end
         M_EVP, M_EVB, M_STP: if (od) mode = M_DRAIN;
         M_DRAIN: if (due_q.size() == 0) mode = M_IDLE;
         default: mode = M_IDLE;
      endcase

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Assert reset between a grant and its return; everything must clear at once.
   task automatic reset_mid_burst();
      evp_req  = 1'b1;
      evb_req  = 1'b1;
      rst      = 1'b0;
      #1;
      check_output("rst rd_en_S",    rd_en_S,    0);
      check_output("rst rd_addr_S",  rd_addr_S,  0);
      check_output("rst evp_rvalid", evp_rvalid, 0);
      check_output("rst evb_rvalid", evb_rvalid, 0);
      check_output("rst addr_err",   addr_err,   0);
      check_output("rst busy",       busy,       0);
      check_output("rst evp_grant",  evp_grant,  0);
      check_output("rst evb_grant",  evb_grant,  0);
      due_q.delete();
      own_q.delete();
      mode        = M_IDLE;
      exp_rd_en   = 1'b0;
      exp_err     = 1'b0;
      exp_rd_addr = '0;
      evp_req     = 1'b0;
      evb_req     = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      cyc += 2;
   endtask

   initial begin
      rst = 1'b0;
      instr = 2'b00; instr_valid = 1'b0; op_done = 1'b0;
      evp_req = 1'b0; evb_req = 1'b0; evp_addr = '0; evb_addr = '0;
      data_S = '0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;

      // EVP streams three back-to-back reads
      apply_stimulus(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, i, 0, 0);
      idle_cycles(3);
      apply_stimulus(0, 0, 1, 0, 0, 0, 0);
      idle_cycles(3);

      // EVB owns S; a stray EVP instruction mid-burst is ignored
      apply_stimulus(1, 2, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) apply_stimulus(i == 2, 1, 0, 1, i, 1, 10 + i);
      apply_stimulus(0, 0, 1, 0, 0, 1, 20);
      idle_cycles(4);
      apply_stimulus(1, 1, 0, 0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 1, 5, 1, 6);
      apply_stimulus(0, 0, 0, 1, 6, 1, 7);
      idle_cycles(2);

      // Range boundary
      apply_stimulus(0, 0, 0, 1, 87, 0, 0);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 88, 1, 127);
      apply_stimulus(0, 0, 0, 1, 127, 0, 0);
      apply_stimulus(0, 0, 1, 0, 0, 0, 0);
      idle_cycles(3);

      // Write-path lock, then the RST instruction in IDLE
      apply_stimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, i, 1, i);
      apply_stimulus(0, 0, 1, 1, 3, 1, 3);
      idle_cycles(3);
      apply_stimulus(1, 3, 0, 0, 0, 0, 0);
      idle_cycles(1);

      // Reset with reads in flight
      apply_stimulus(1, 1, 0, 0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 1, 30, 0, 0);
      apply_stimulus(0, 0, 0, 1, 31, 0, 0);
      reset_mid_burst();
      idle_cycles(4);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         int pa, ba;
         pa = ($urandom_range(0, 3) == 0) ? $urandom_range(84, 127) : $urandom_range(0, 87);
         ba = ($urandom_range(0, 3) == 0) ? $urandom_range(84, 127) : $urandom_range(0, 87);
         apply_stimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3),
                        $urandom_range(0, 9) == 0,
                        $urandom_range(0, 9) < 7, pa,
                        $urandom_range(0, 9) < 7, ba);
      end
      idle_cycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
